lse_reduce_ctrl: RTL and testbench

Sequencing controller that reduces a streamed vector of log-domain values to one log-sum-exp result by driving the `lse_add` processing element iteratively. It sits directly upstream of `lse_add`: it issues operand pairs (running accumulator, next element) and consumes `lse_add`'s registered `result`/`valid_out`. It presents a valid/ready input stream and a valid/ready output stream.

---
 rtl/lse_reduce_ctrl.sv | 135 +++++++++++++
 tb/tb_lse_reduce_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lse_reduce_ctrl.sv
// Streams log-domain elements through an external lse_add PE and folds them into one log-sum-exp result.
// Optional build macro LSE_REDUCE_NEGINF_SKIP_EN: NEG_INF elements are counted but never issued to the PE.
module lse_reduce_ctrl #(
    parameter int WIDTH    = 24,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_last,
    output logic                add_enable,
    output logic [WIDTH-1:0]    add_operand_a,
    output logic [WIDTH-1:0]    add_operand_b,
    output logic [1:0]          add_pe_mode,
    input  logic [WIDTH-1:0]    add_result,
    input  logic                add_valid,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [CNT_BITS-1:0] out_count
);

    localparam logic [WIDTH-1:0]    NEG_INF  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [WIDTH-1:0]    acc_r, acc_s;
    logic [CNT_BITS-1:0] cnt_r, cnt_s;
    logic                last_r, last_s;
    logic                en_r, en_s;
    logic [WIDTH-1:0]    opa_r, opa_s;
    logic [WIDTH-1:0]    opb_r, opb_s;
    logic                out_valid_r;
    logic                accept_s;

    assign accept_s      = in_valid && (state_r == ST_ACCEPT);
    assign in_ready      = (state_r == ST_ACCEPT) && !rst;
    assign add_enable    = en_r;
    assign add_operand_a = opa_r;
    assign add_operand_b = opb_r;
    assign add_pe_mode   = 2'b00;
    assign out_valid     = out_valid_r;
    assign out_data      = acc_r;
    assign out_count     = cnt_r;

    // Next-state and datapath decode; add_enable defaults low so an issue is a one-cycle pulse.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        en_s    = 1'b0;
        opa_s   = opa_r;
        opb_s   = opb_r;
        case (state_r)
            ST_ACCEPT: begin
                if (accept_s) begin
                    cnt_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
                    last_s = in_last;
`ifdef LSE_REDUCE_NEGINF_SKIP_EN
                    if (in_data == NEG_INF) begin
                        state_s = in_last ? ST_DONE : ST_ACCEPT;
                    end else begin
                        opa_s   = acc_r;
                        opb_s   = in_data;
                        en_s    = 1'b1;
                        state_s = ST_WAIT;
                    end
`else
                    opa_s   = acc_r;
                    opb_s   = in_data;
                    en_s    = 1'b1;
                    state_s = ST_WAIT;
`endif
                end else begin
                    state_s = ST_ACCEPT;
                end
            end
            ST_WAIT: begin
                if (add_valid) begin
                    acc_s   = add_result;
                    state_s = last_r ? ST_DONE : ST_ACCEPT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    acc_s   = NEG_INF;
                    cnt_s   = CNT_ZERO;
                    state_s = ST_ACCEPT;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_ACCEPT;
            end
        endcase
    end

    // State, accumulator, counter and registered PE/output drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_ACCEPT;
            acc_r       <= NEG_INF;
            cnt_r       <= CNT_ZERO;
            last_r      <= 1'b0;
            en_r        <= 1'b0;
            opa_r       <= NEG_INF;
            opb_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            last_r      <= last_s;
            en_r        <= en_s;
            opa_r       <= opa_s;
            opb_r       <= opb_s;
            out_valid_r <= (state_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_lse_reduce_ctrl.sv
// Randomised and directed bench for lse_reduce_ctrl with a behavioural stand-in for the lse_add PE.
module tb_lse_reduce_ctrl;

    localparam int WIDTH = 24;
    localparam int CNT_BITS = 8;
    localparam logic [23:0] NEG_INF = 24'h800000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [23:0] in_data;
    logic        add_enable;
    logic [23:0] add_operand_a, add_operand_b;
    logic [1:0]  add_pe_mode;
    logic [23:0] pe_result = 24'h0;
    logic        pe_valid = 1'b0;
    logic        out_valid, out_ready;
    logic [23:0] out_data;
    logic [7:0]  out_count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lse_reduce_ctrl #(.WIDTH(WIDTH), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .add_enable(add_enable), .add_operand_a(add_operand_a), .add_operand_b(add_operand_b),
        .add_pe_mode(add_pe_mode), .add_result(pe_result), .add_valid(pe_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    // Base-2 log-sum-exp in Q.10 with a crude correction term; NEG_INF is the identity.
    function automatic logic [23:0] pe_lse(input logic [23:0] a, input logic [23:0] b);
        logic signed [24:0] sa, sb, mx, d, s;
        logic [23:0] corr;
        if (a == NEG_INF) return b;
        if (b == NEG_INF) return a;
        sa = {a[23], a};
        sb = {b[23], b};
        mx = (sa > sb) ? sa : sb;
        d  = (sa > sb) ? sa - sb : sb - sa;
        corr = (d < 25'sd16384) ? (24'h000400 >> d[23:10]) : 24'h000000;
        s = mx + $signed({1'b0, corr});
        if (s > 25'sh07FFFFF) return 24'h7FFFFF;
        return s[23:0];
    endfunction

    // PE stand-in: not tied to rst, so a result in flight survives a controller reset.
    always @(posedge clk) begin
        pe_valid <= add_enable;
        if (add_enable) pe_result <= pe_lse(add_operand_a, add_operand_b);
    end

    task automatic send(input logic [23:0] d, input logic last, input logic [23:0] exp_acc);
        int t;
        logic skipped;
        t = 0;
        skipped = 1'b0;
`ifdef LSE_REDUCE_NEGINF_SKIP_EN
        skipped = (d == NEG_INF);
`endif
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        n_checks++;
        if (!in_ready) begin
            n_fail++; $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0; in_last = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        if (skipped) begin
            n_checks++;
            if (add_enable !== 1'b0) begin n_fail++; $display("FAIL skip_no_issue: add_enable=%b required 0", add_enable); end
            n_checks++;
            if (!last && in_ready !== 1'b1) begin n_fail++; $display("FAIL skip_ready: in_ready=%b required 1", in_ready); end
            else if (last && out_valid !== 1'b1) begin n_fail++; $display("FAIL skip_done: out_valid=%b required 1", out_valid); end
            return;
        end
        n_checks++;
        if (add_enable !== 1'b1 || in_ready !== 1'b0 || add_operand_a !== exp_acc || add_operand_b !== d) begin
            n_fail++;
            $display("FAIL issue: en=%b rdy=%b a=%h b=%h required en=1 rdy=0 a=%h b=%h",
                     add_enable, in_ready, add_operand_a, add_operand_b, exp_acc, d);
        end
        @(negedge clk);
        n_checks++;
        if (add_enable !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL wait_cycle: en=%b rdy=%b ov=%b required 0 0 0", add_enable, in_ready, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (!last && in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_return: in_ready=%b required 1", in_ready); end
        else if (last && (out_valid !== 1'b1 || in_ready !== 1'b0)) begin
            n_fail++; $display("FAIL done_entry: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
        end
    endtask

    task automatic recv(input logic [23:0] exp_data, input logic [7:0] exp_cnt, input int hold);
        int t;
        t = 0;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data || out_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL result: valid=%b data=%h count=%0d required 1 %h %0d", out_valid, out_data, out_count, exp_data, exp_cnt);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data || out_count !== exp_cnt || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold: valid=%b data=%h count=%0d rdy=%b required 1 %h %0d 0", out_valid, out_data, out_count, in_ready, exp_data, exp_cnt);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== NEG_INF || out_count !== 8'd0) begin
            n_fail++;
            $display("FAIL handshake: valid=%b rdy=%b data=%h count=%0d required 0 1 %h 0", out_valid, in_ready, out_data, out_count, NEG_INF);
        end
    endtask

    task automatic run_vector(input logic [23:0] v[$], input int hold);
        logic [23:0] acc;
        int n;
        acc = NEG_INF;
        n = v.size();
        for (int i = 0; i < n; i++) begin
            send(v[i], (i == n - 1), acc);
            acc = pe_lse(acc, v[i]);
        end
        recv(acc, (n > 255) ? 8'd255 : n[7:0], hold);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = 24'h0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || add_enable !== 1'b0 || add_operand_a !== NEG_INF || add_operand_b !== 24'h0 ||
            add_pe_mode !== 2'b00 || out_valid !== 1'b0 || out_data !== NEG_INF || out_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b en=%b a=%h b=%h mode=%b ov=%b od=%h oc=%0d",
                     in_ready, add_enable, add_operand_a, add_operand_b, add_pe_mode, out_valid, out_data, out_count);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release: in_ready=%b required 1", in_ready); end
    endtask

    task automatic test_single;
        logic [23:0] v[$];
        v = '{24'h001234};
        run_vector(v, 0);
    endtask

    task automatic test_back_to_back_hold;
        logic [23:0] v[$];
        v = '{24'h000000, 24'h000000};
        run_vector(v, 0);
        run_vector(v, 5);
        v = '{24'h000800};
        run_vector(v, 0);
    endtask

    task automatic test_neginf_first;
        logic [23:0] v[$];
        v = '{NEG_INF, 24'h000800};
        run_vector(v, 1);
    endtask

    task automatic test_reset_midop;
        logic [23:0] v[$];
        @(negedge clk);
        in_valid = 1'b1; in_data = 24'h002000; in_last = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || add_enable !== 1'b0 || add_operand_a !== NEG_INF || add_operand_b !== 24'h0 ||
            out_valid !== 1'b0 || out_data !== NEG_INF || out_count !== 8'd0) begin
            n_fail++;
            $display("FAIL midop_reset: rdy=%b en=%b a=%h b=%h ov=%b od=%h oc=%0d",
                     in_ready, add_enable, add_operand_a, add_operand_b, out_valid, out_data, out_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== NEG_INF || out_count !== 8'd0) begin
            n_fail++;
            $display("FAIL late_valid: rdy=%b ov=%b od=%h oc=%0d required 1 0 %h 0", in_ready, out_valid, out_data, out_count, NEG_INF);
        end
        v = '{24'h000400};
        run_vector(v, 0);
    endtask

    task automatic test_count_sat;
        logic [23:0] v[$];
        v = {};
        for (int i = 0; i < 300; i++) v.push_back(NEG_INF);
        run_vector(v, 0);
    endtask

    task automatic test_random;
        logic [23:0] v[$];
        int len;
        for (int k = 0; k < 25; k++) begin
            v = {};
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) v.push_back(NEG_INF);
                else v.push_back(24'($urandom_range(0, 24576)) - 24'h003000);
            end
            run_vector(v, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back_hold;
        test_neginf_first;
        test_reset_midop;
        test_count_sat;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
